// File: rtl/alu_ctrl_pkg.sv
// ALU control op codes and execute-stage FSM encoding, shared between the
// ALU control decoder and the execute-stage ALU.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_SLL   = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_MULA  = 4'd5,
    ALU_SUB   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_ADDU  = 4'd8,
    ALU_SUBU  = 4'd9,
    ALU_XOR   = 4'd10,
    ALU_SLTU  = 4'd11,
    ALU_NOR   = 4'd12,
    ALU_SRA   = 4'd13,
    ALU_LUI   = 4'd14,
    ALU_UNDEF = 4'd15
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_e;

  // Signed overflow from operand and result sign bits.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per clock,
// WIDTH steps per multiply, product truncated to WIDTH bits.
module alu_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_prod_s;
  logic             last_s;

  // Product including the current step, so the final step is visible
  // to the accumulator on the same edge that retires it.
  assign step_prod_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign last_s      = busy_q && (cnt_q == LAST_CNT);

  // Next-state logic for the shift-add datapath and step counter.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (load) begin
      mcand_d  = A;
      mplier_d = B;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      prod_d   = step_prod_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_ONE;
      busy_d   = !last_s;
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Datapath registers; reset abandons any multiply in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign last    = last_s;
  assign product = step_prod_s;

endmodule

// File: rtl/alu_mula_exec.sv
// Execute-stage ALU: single-cycle ops with registered result, plus a
// multi-cycle multiply-accumulate into a persistent accumulator.
module alu_mula_exec
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic             AccClear,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] Acc
);

  exec_state_e      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] sum_s, diff_s, alu_res_s, mac_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic             alu_ovf_s;
  logic             slt_s, sltu_s;
  logic             mul_load_s, mul_busy_s, mul_last_s;
  logic [WIDTH-1:0] mul_product_s;

  alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .Reset   (Reset),
    .load    (mul_load_s),
    .A       (BusA),
    .B       (BusB),
    .busy    (mul_busy_s),
    .last    (mul_last_s),
    .product (mul_product_s)
  );

  assign sum_s   = BusA + BusB;
  assign diff_s  = BusA - BusB;
  assign shamt_s = BusA[SHAMT_W-1:0];
  assign slt_s   = $signed(BusA) < $signed(BusB);
  assign sltu_s  = BusA < BusB;
  assign mac_s   = acc_q + mul_product_s;

  // Single-cycle operation result and overflow flag.
  always_comb begin
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (ALUCtrl)
      ALU_AND:  alu_res_s = BusA & BusB;
      ALU_OR:   alu_res_s = BusA | BusB;
      ALU_XOR:  alu_res_s = BusA ^ BusB;
      ALU_NOR:  alu_res_s = ~(BusA | BusB);
      ALU_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_overflow(BusA[WIDTH-1], BusB[WIDTH-1], sum_s[WIDTH-1]);
      end
      ALU_ADDU: alu_res_s = sum_s;
      ALU_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = sub_overflow(BusA[WIDTH-1], BusB[WIDTH-1], diff_s[WIDTH-1]);
      end
      ALU_SUBU: alu_res_s = diff_s;
      ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, sltu_s};
      ALU_SLL:  alu_res_s = BusB << shamt_s;
      ALU_SRL:  alu_res_s = BusB >> shamt_s;
      ALU_SRA:  alu_res_s = $signed(BusB) >>> shamt_s;
      ALU_LUI:  alu_res_s = BusB << 5'd16;
      default: begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // FSM next state, output registers and accumulator update.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    acc_d      = acc_q;
    mul_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (AccClear) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q;
        end
        if (Start) begin
          if (ALUCtrl == ALU_MULA) begin
            mul_load_s = 1'b1;
            state_d    = ST_MUL;
          end else begin
            result_d = alu_res_s;
            zero_d   = (alu_res_s == '0);
            ovf_d    = alu_ovf_s;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        // On the final step Result reports old Acc + product even if a
        // clear arrives on that edge; the clear only wins for Acc itself.
        if (mul_last_s) begin
          result_d = mac_s;
          zero_d   = (mac_s == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          acc_d    = AccClear ? '0 : mac_s;
        end else if (!mul_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = AccClear ? '0 : acc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
    end
  end

  assign Busy     = (state_q == ST_MUL);
  assign Done     = done_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign Acc      = acc_q;

endmodule

// File: tb/tb_alu_mula_exec.sv
// Scoreboard bench for alu_mula_exec: the driver pushes expected responses,
// a monitor pops and compares on every Done pulse.
module tb_alu_mula_exec;
  import alu_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  ALUCtrl = 4'd0;
  logic [31:0] BusA = 32'd0;
  logic [31:0] BusB = 32'd0;
  logic        AccClear = 1'b0;
  logic        Busy, Done, Zero, Overflow;
  logic [31:0] Result, Acc;

  alu_mula_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .AccClear(AccClear), .Busy(Busy),
    .Done(Done), .Result(Result), .Zero(Zero), .Overflow(Overflow), .Acc(Acc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic [31:0] acc;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] acc_model = 32'd0;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: plain arithmetic on the op definitions.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic v);
    longint sa, sb, s, maxv, minv;
    logic signed [31:0] sbv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxv = 64'sd2147483647;
    minv = -maxv - 64'sd1;
    sbv = b;
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = a + b; v = (s > maxv) || (s < minv); end
      4'd3:  r = b << a[4:0];
      4'd4:  r = b >> a[4:0];
      4'd6:  begin s = sa - sb; r = a - b; v = (s > maxv) || (s < minv); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = a + b;
      4'd9:  r = a - b;
      4'd10: r = a ^ b;
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      4'd13: r = sbv >>> a[4:0];
      4'd14: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic clr_final);
    exp_t e;
    logic [31:0] r;
    logic v;
    logic [63:0] p;
    if (op == 4'd5) begin
      p = {32'h0, a} * {32'h0, b};
      r = acc_model + p[31:0];
      v = 1'b0;
      e.acc = clr_final ? 32'd0 : r;
      e.due = cyc + 1 + 32;
    end else begin
      ref_alu(op, a, b, r, v);
      e.acc = acc_model;
      e.due = cyc + 1;
    end
    e.res = r;
    e.ovf = v;
    acc_model = e.acc;
    exp_q.push_back(e);
    Start = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Waits for Busy to drop, optionally injecting a Start, AccClear or Reset
  // at the n-th busy cycle.
  task automatic wait_idle(input int start_at, input int clr_at,
                           input int rst_at, input int exp_n);
    int n;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      if (n == rst_at) begin
        #1 Reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_ovf", {31'd0, Overflow}, 32'd0);
        chk("rst_acc", Acc, 32'd0);
        exp_q.delete();
        acc_model = 32'd0;
        @(negedge CLK);
        Reset = 1'b0;
        return;
      end
      Start = (n == start_at);
      if (n == start_at) begin
        ALUCtrl = 4'd2; BusA = 32'd1; BusB = 32'd1;
      end
      AccClear = (n == clr_at);
      @(negedge CLK);
    end
    Start = 1'b0;
    AccClear = 1'b0;
    chk("mula_timeout", {31'd0, Busy}, 32'd0);
    if (exp_n > 0) chk("busy_cycles", n, exp_n);
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: Done=1 with no request outstanding, expected Done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", Result, mon_e.res);
        chk("zero", {31'd0, Zero}, {31'd0, (mon_e.res == 32'd0)});
        chk("overflow", {31'd0, Overflow}, {31'd0, mon_e.ovf});
        chk("acc", Acc, mon_e.acc);
        chk("done_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] picks [5];

    repeat (3) @(negedge CLK);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    chk("reset_zero", {31'd0, Zero}, 32'd0);
    chk("reset_ovf", {31'd0, Overflow}, 32'd0);
    chk("reset_acc", Acc, 32'd0);
    Reset = 1'b0;
    @(negedge CLK);

    issue(4'd2, 32'd7, 32'd5, 1'b0);
    issue(4'd6, 32'd5, 32'd5, 1'b0);
    issue(4'd2, 32'h7FFFFFFF, 32'd1, 1'b0);
    issue(4'd8, 32'h7FFFFFFF, 32'd1, 1'b0);
    issue(4'd6, 32'h80000000, 32'd1, 1'b0);
    issue(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(4'd11, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(4'd13, 32'd4, 32'h80000000, 1'b0);
    issue(4'd4, 32'd4, 32'h80000000, 1'b0);
    issue(4'd14, 32'd0, 32'h00001234, 1'b0);
    issue(4'd15, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge CLK);

    // MULA 3*4 from a zero accumulator, then 5*6 with a Start during Busy.
    issue(4'd5, 32'd3, 32'd4, 1'b0);
    wait_idle(0, 0, 0, 32);
    issue(4'd5, 32'd5, 32'd6, 1'b0);
    wait_idle(5, 0, 0, 32);
    @(negedge CLK);
    chk("acc_after_mula", Acc, 32'd42);

    AccClear = 1'b1;
    @(negedge CLK);
    AccClear = 1'b0;
    acc_model = 32'd0;
    chk("acc_clear_idle", Acc, 32'd0);

    issue(4'd5, 32'd1, 32'd1, 1'b0);
    wait_idle(0, 0, 0, 32);
    issue(4'd5, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle(0, 0, 0, 32);

    // Clear on the same edge as a MULA start: accumulate onto zero.
    acc_model = 32'd0;
    AccClear = 1'b1;
    issue(4'd5, 32'd9, 32'd9, 1'b0);
    AccClear = 1'b0;
    wait_idle(0, 0, 0, 32);

    // Clear mid-multiply, then clear on the final edge.
    acc_model = 32'd0;
    issue(4'd5, 32'd10, 32'd11, 1'b0);
    wait_idle(0, 10, 0, 32);
    issue(4'd5, 32'd3, 32'd3, 1'b1);
    wait_idle(0, 32, 0, 32);
    @(negedge CLK);
    chk("acc_clear_final", Acc, 32'd0);

    // Reset during a multiply abandons it.
    issue(4'd5, 32'd123, 32'd456, 1'b0);
    wait_idle(0, 0, 10, 0);
    issue(4'd2, 32'd1, 32'd1, 1'b0);

    picks[0] = 32'h00000000; picks[1] = 32'h7FFFFFFF; picks[2] = 32'h80000000;
    picks[3] = 32'hFFFFFFFF; picks[4] = 32'h00000001;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        issue(4'd5, a, b, 1'b0);
        wait_idle(0, 0, 0, 32);
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5) op = 4'd2;
        issue(op, a, b, 1'b0);
      end
    end

    repeat (4) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mula_exec.md
Name: alu_mula_exec

Overview:
- Execution-stage ALU directly downstream of the ALU control decoder. Consumes its 4-bit ALUCtrl code plus two 32-bit operands.
- Performs all single-cycle ALU operations with a registered result.
- Performs MULA (multiply-accumulate) as an iterative shift-add multiply into a persistent accumulator.
- Start/Busy/Done handshake lets the datapath controller stall while MULA is running.

Parameters:
- WIDTH, 32, operand, result and accumulator width.
- SHAMT_W, 5, number of BusA LSBs used as the shift amount (log2 WIDTH).

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle request; samples ALUCtrl, BusA, BusB
- ALUCtrl  in  4  operation code from ALU control
- BusA  in  WIDTH  operand A; BusA[SHAMT_W-1:0] is the shift amount for shifts
- BusB  in  WIDTH  operand B; value shifted by shifts; LUI source
- AccClear  in  1  synchronous clear of the MULA accumulator
- Busy  out  1  high while a MULA is in progress
- Done  out  1  one-cycle pulse; Result, Zero and Overflow valid from this cycle
- Result  out  WIDTH  registered result; held until the next Done
- Zero  out  1  Result == 0, updated with Result
- Overflow  out  1  signed overflow for ADD/SUB only; 0 for every other op
- Acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (async, any time, including mid-MULA):
  - Busy, Done, Result, Zero, Overflow and Acc all go to 0; the FSM goes to IDLE.
  - An in-flight multiply is abandoned and no Done is issued for it.
- FSM states: IDLE, MUL.
- Single-cycle ops (IDLE, Start=1, ALUCtrl != MULA):
  - Result, Zero, Overflow registered at the same edge that samples Start; Done=1 for exactly the following cycle. Latency is 1 cycle; FSM stays in IDLE.
  - Back-to-back Starts are legal, one per cycle.
- Op semantics:
  - AND, OR, XOR, NOR: bitwise.
  - ADD, ADDU, SUB, SUBU: modulo 2^WIDTH.
  - Overflow=1 for ADD when A and B have the same sign and the result sign differs; for SUB when A and B have different signs and the result sign differs from A. ADDU/SUBU never flag.
  - SLT (signed) and SLTU (unsigned): result is {0...,A<B}.
  - SLL, SRL: logical shift of B by A[4:0]. SRA: arithmetic shift of B by A[4:0].
  - LUI: {B[15:0], 16'b0}.
  - Undefined code 4'b1111: Result=0, Zero=1, Done still pulses.
- MULA (Start=1 in IDLE, ALUCtrl=MULA):
  - At edge k: latch multiplicand=A, multiplier=B, product=0, count=0; Busy=1; go to MUL.
  - Each MUL edge: if multiplier[0], product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. All product arithmetic is WIDTH bits; high bits are discarded.
  - On the WIDTH-th MUL edge (edge k+WIDTH): Acc <= Acc + product_final, Result <= same value, Zero updated, Overflow=0, Busy=0, Done=1 for the next cycle, return to IDLE. Accumulation wraps modulo 2^WIDTH.
- Start while Busy: ignored entirely, with no queueing. The controller must hold the request until Done.
- AccClear:
  - In IDLE: Acc <= 0 at the next edge. If Start=MULA on the same edge, the clear applies first, so the MULA accumulates onto 0.
  - In MUL, not on the final edge: Acc <= 0 immediately; the final accumulate adds onto 0.
  - On the final MUL edge: Result reports old Acc + product, and Acc <= 0 (clear wins for Acc).
- Done is never asserted in two consecutive cycles for the same request. Result is stable between Done pulses.

Decomposition:
- Shared package alu_ctrl_pkg: the 4-bit ALU op constants
  - AND=0, OR=1, ADD=2, SLL=3, SRL=4, MULA=5, SUB=6, SLT=7, ADDU=8, SUBU=9, XOR=10, SLTU=11, NOR=12, SRA=13, LUI=14
  - FSM state encoding.
  - Package is shared with the ALU control decoder.
- One sub-module, alu_seq_multiplier: shift-add datapath and step counter.
  - Ports: CLK, Reset, load, A, B, busy, last, product.
  - The top level owns the FSM, accumulator, single-cycle ops and output registers.

Test Plan:
- ADD A=7, B=5, Start 1 cycle -> Done high the next cycle; Result=12, Zero=0, Overflow=0. Then SUB 5-5 -> Result=0, Zero=1.
- ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow=1. ADDU same operands -> Overflow=0. SUB 0x80000000-1 -> 0x7FFFFFFF, Overflow=1.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same -> 0. SRA B=0x80000000 by A=4 -> 0xF8000000. SRL same -> 0x08000000. LUI B=0x1234 -> 0x12340000.
- From reset, MULA 3*4 -> Busy for 32 cycles, Done on cycle 33, Result=Acc=12. Then MULA 5*6 -> 42. Start ADD pulsed while Busy -> ignored, no extra Done. AccClear in IDLE -> Acc=0.
- MULA 0xFFFFFFFF*2 with Acc=1 -> Result=0xFFFFFFFF (low 32 bits of product wrapped, plus 1).
- Reset asserted at MUL cycle 10 -> outputs go to 0 immediately, no Done. Next ADD 1+1 -> Result=2 one cycle later.
